// File: rtl/fx2_cmd_parser.sv
// fx2_cmd_parser
//   Decodes host command frames from the FX2 OUT-FIFO byte stream.
//   Frame: 0xAA sync, type byte, payload.
//     type 0x01 -> 2 payload bytes (target, action)  -> cmd_stb
//     type 0x05 -> 6 payload bytes (addr LE, data LE) -> reg_wr
//   Bad type bytes and frames stalled for TIMEOUT idle cycles are dropped
//   and counted in a saturating error counter.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_data/in_valid  byte stream from the FIFO reader
//   in_ready          byte accepted when in_valid && in_ready (low in EMIT)
//   reg_addr/reg_data register write fields, held between strobes
//   reg_wr            one-cycle register write strobe
//   cmd_target/action action fields, held between strobes
//   cmd_stb           one-cycle action strobe
//   frame_err         one-cycle pulse per dropped frame
//   err_count         dropped-frame count, saturates at 0xFF
//
// state   | meaning
// --------+-----------------------------------------------
// HUNT    | discard bytes until 0xAA
// TYPE    | sync seen, waiting for type byte
// PAYLOAD | collecting payload bytes into assembly register
// EMIT    | one-cycle strobe, input held off

module fx2_cmd_parser #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_data,
  output logic        reg_wr,
  output logic [7:0]  cmd_target,
  output logic [7:0]  cmd_action,
  output logic        cmd_stb,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_TYPE,
    S_PAYLOAD,
    S_EMIT
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_idle_cnt;
  logic [2:0]    r_remaining;
  logic [2:0]    r_idx;
  logic          r_is_reg;
  logic [47:0]   r_asm;
  logic [15:0]   r_reg_addr;
  logic [31:0]   r_reg_data;
  logic [7:0]    r_cmd_target;
  logic [7:0]    r_cmd_action;
  logic          r_frame_err;
  logic [7:0]    r_err_count;

  logic          w_in_ready;
  logic          w_xfer;
  logic          w_idle_tc;
  logic          w_err;
  logic          w_reg_wr;
  logic          w_cmd_stb;
  logic [47:0]   w_asm_full;

  // Idle timer counts down from TIMEOUT-1; reaching zero on an idle cycle
  // means this is the TIMEOUT-th consecutive idle cycle.
  assign w_idle_tc = (r_idle_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    w_reg_wr     = 1'b0;
    w_cmd_stb    = 1'b0;
    w_err        = 1'b0;
    if (r_state == S_EMIT) begin
      w_in_ready = 1'b0;
    end
    w_xfer = in_valid && w_in_ready;

    case (r_state)
      S_HUNT: begin
        if (w_xfer && in_data == 8'hAA) begin
          w_state_next = S_TYPE;
        end
      end
      S_TYPE: begin
        if (w_xfer) begin
          case (in_data)
            8'h01, 8'h05: w_state_next = S_PAYLOAD;
            8'hAA:        w_state_next = S_TYPE;
            default: begin
              w_err        = 1'b1;
              w_state_next = S_HUNT;
            end
          endcase
        end else if (w_idle_tc) begin
          w_err        = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          if (r_remaining == 3'd1) begin
            w_state_next = S_EMIT;
          end
        end else if (w_idle_tc) begin
          w_err        = 1'b1;
          w_state_next = S_HUNT;
        end
      end
      S_EMIT: begin
        if (r_is_reg) begin
          w_reg_wr = 1'b1;
        end else begin
          w_cmd_stb = 1'b1;
        end
        w_state_next = S_HUNT;
      end
      default: w_state_next = S_HUNT;
    endcase
  end

  // Assembly register with the incoming byte already merged, so the output
  // fields can be loaded on the same edge that accepts the last byte.
  always_comb begin
    w_asm_full = r_asm;
    w_asm_full[{r_idx, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt   <= '0;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_is_reg     <= 1'b0;
      r_asm        <= '0;
      r_reg_addr   <= '0;
      r_reg_data   <= '0;
      r_cmd_target <= '0;
      r_cmd_action <= '0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end

      case (r_state)
        S_HUNT: begin
          if (w_xfer && in_data == 8'hAA) begin
            r_idle_cnt <= IDLE_LOAD;
          end
        end
        S_TYPE: begin
          if (w_xfer) begin
            r_idle_cnt <= IDLE_LOAD;
            r_idx      <= '0;
            if (in_data == 8'h01) begin
              r_remaining <= 3'd2;
              r_is_reg    <= 1'b0;
            end else if (in_data == 8'h05) begin
              r_remaining <= 3'd6;
              r_is_reg    <= 1'b1;
            end
          end else if (!w_idle_tc) begin
            r_idle_cnt <= r_idle_cnt - 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_idle_cnt  <= IDLE_LOAD;
            r_asm       <= w_asm_full;
            r_idx       <= r_idx + 3'd1;
            r_remaining <= r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              if (r_is_reg) begin
                r_reg_addr <= w_asm_full[15:0];
                r_reg_data <= w_asm_full[47:16];
              end else begin
                r_cmd_target <= w_asm_full[7:0];
                r_cmd_action <= w_asm_full[15:8];
              end
            end
          end else if (!w_idle_tc) begin
            r_idle_cnt <= r_idle_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign reg_wr     = w_reg_wr;
  assign cmd_stb    = w_cmd_stb;
  assign reg_addr   = r_reg_addr;
  assign reg_data   = r_reg_data;
  assign cmd_target = r_cmd_target;
  assign cmd_action = r_cmd_action;
  assign frame_err  = r_frame_err;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_fx2_cmd_parser.sv
// Testbench for fx2_cmd_parser: directed frames followed by randomized
// frames, gaps and resets, compared every cycle against a byte-queue model.

module tb_fx2_cmd_parser;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] reg_addr;
  logic [31:0] reg_data;
  logic        reg_wr;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_action;
  logic        cmd_stb;
  logic        frame_err;
  logic [7:0]  err_count;

  fx2_cmd_parser #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .reg_wr     (reg_wr),
    .cmd_target (cmd_target),
    .cmd_action (cmd_action),
    .cmd_stb    (cmd_stb),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress, idle run length,
  // pending strobe kind (0 none, 1 action, 2 register write).
  logic [7:0]  mf[$];
  int          m_idle;
  int          m_pend;
  bit          m_err_pulse;
  int          m_err_cnt;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  logic [7:0]  m_target;
  logic [7:0]  m_action;

  task automatic model_reset();
    mf.delete();
    m_idle = 0;
    m_pend = 0;
    m_err_pulse = 0;
    m_err_cnt = 0;
    m_addr = 0;
    m_data = 0;
    m_target = 0;
    m_action = 0;
  endtask

  task automatic model_advance(input logic v, input logic [7:0] d, output bit accepted);
    bit new_err = 0;
    int need;
    accepted = 0;
    if (m_pend != 0) begin
      m_pend = 0;
    end else if (v) begin
      accepted = 1;
      if (mf.size() == 0) begin
        if (d == 8'hAA) begin
          mf.push_back(d);
          m_idle = 0;
        end
      end else if (mf.size() == 1) begin
        m_idle = 0;
        if (d == 8'h01 || d == 8'h05) begin
          mf.push_back(d);
        end else if (d != 8'hAA) begin
          new_err = 1;
          mf.delete();
        end
      end else begin
        m_idle = 0;
        mf.push_back(d);
        need = (mf[1] == 8'h05) ? 8 : 4;
        if (mf.size() == need) begin
          if (need == 8) begin
            m_addr = 16'(mf[2]) + 16'(mf[3]) * 256;
            m_data = 32'(mf[4]) + 32'(mf[5]) * 256 + 32'(mf[6]) * 65536 + 32'(mf[7]) * 16777216;
            m_pend = 2;
          end else begin
            m_target = mf[2];
            m_action = mf[3];
            m_pend = 1;
          end
          mf.delete();
        end
      end
    end else if (mf.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        new_err = 1;
        mf.delete();
      end
    end
    m_err_pulse = new_err;
    if (new_err && m_err_cnt < 255) m_err_cnt++;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic [7:0] d, output bit accepted);
    in_valid = v;
    in_data  = d;
    #1;
    check("in_ready",   32'(in_ready),   32'(m_pend == 0));
    check("reg_wr",     32'(reg_wr),     32'(m_pend == 2));
    check("cmd_stb",    32'(cmd_stb),    32'(m_pend == 1));
    check("frame_err",  32'(frame_err),  32'(m_err_pulse));
    check("err_count",  32'(err_count),  32'(m_err_cnt));
    check("reg_addr",   32'(reg_addr),   32'(m_addr));
    check("reg_data",   reg_data,        m_data);
    check("cmd_target", 32'(cmd_target), 32'(m_target));
    check("cmd_action", 32'(cmd_action), 32'(m_action));
    model_advance(v, d, accepted);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 8'($urandom), acc);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit acc;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, d, acc);
      if (acc) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_bound: byte 0x%0h not accepted within 4 cycles", d);
  endtask

  logic [7:0] sq[$];

  task automatic play(input bit gappy);
    for (int i = 0; i < sq.size(); i++) begin
      if (gappy && $urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      send_byte(sq[i]);
    end
    sq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0, 1:    return 8'hAA;
      2:       return 8'h01;
      3:       return 8'h05;
      4:       return 8'h07;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic push_reg_frame();
    sq.push_back(8'hAA);
    sq.push_back(8'h05);
    repeat (6) sq.push_back(8'($urandom));
  endtask

  task automatic rand_frame();
    logic [7:0] b;
    int cut;
    logic [7:0] rest[$];
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        sq.push_back(8'hAA);
        sq.push_back(8'h01);
        sq.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 2)) : 8'($urandom));
        sq.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 2)) : 8'($urandom));
        play(1);
      end
      3, 4, 5: begin
        push_reg_frame();
        play(1);
      end
      6: begin
        repeat ($urandom_range(1, 4)) sq.push_back(pick_byte());
        play(1);
      end
      7: begin
        b = 8'($urandom);
        while (b == 8'h01 || b == 8'h05 || b == 8'hAA) b = 8'($urandom);
        sq.push_back(8'hAA);
        sq.push_back(b);
        play(1);
      end
      8: begin
        sq.push_back(8'hAA);
        sq.push_back(8'hAA);
        sq.push_back(8'h01);
        sq.push_back(8'($urandom));
        sq.push_back(8'($urandom));
        play(1);
      end
      default: begin
        push_reg_frame();
        cut = $urandom_range(1, 7);
        for (int i = cut; i < 8; i++) rest.push_back(sq[i]);
        sq = sq[0:cut-1];
        play(0);
        idle(TIMEOUT - 1 + $urandom_range(0, 1));
        sq = rest;
        play(0);
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(2);

    // Register write with trailing junk.
    sq = '{8'hAA, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02, 8'hFF, 8'hFF, 8'hFF};
    play(0);
    idle(2);
    check("t1_addr", 32'(reg_addr), 32'h0000_0004);
    check("t1_data", reg_data, 32'h0240_0000);
    check("t1_errs", 32'(err_count), 32'd0);

    // Back-to-back action frames.
    sq = '{8'hAA, 8'h01, 8'h01, 8'h01, 8'hAA, 8'h01, 8'h02, 8'h01};
    play(0);
    idle(2);
    check("t2_target", 32'(cmd_target), 32'h02);
    check("t2_action", 32'(cmd_action), 32'h01);

    // Invalid type then a good action frame.
    sq = '{8'hAA, 8'h07, 8'hAA, 8'h01, 8'h02, 8'h02};
    play(0);
    idle(2);
    check("t3_errs",   32'(err_count),  32'd1);
    check("t3_target", 32'(cmd_target), 32'h02);
    check("t3_action", 32'(cmd_action), 32'h02);

    // Resync on repeated sync byte.
    sq = '{8'hAA, 8'hAA, 8'h01, 8'h01, 8'h02};
    play(0);
    idle(2);
    check("t4_errs",   32'(err_count),  32'd1);
    check("t4_target", 32'(cmd_target), 32'h01);
    check("t4_action", 32'(cmd_action), 32'h02);

    // Longest legal gap, then the shortest aborting gap.
    do_reset();
    sq = '{8'hAA, 8'h05, 8'h04};
    play(0);
    idle(TIMEOUT - 1);
    sq = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
    play(0);
    idle(2);
    check("t5_addr", 32'(reg_addr), 32'h0000_0004);
    check("t5_data", reg_data, 32'h0240_0000);
    check("t5_errs", 32'(err_count), 32'd0);
    sq = '{8'hAA, 8'h05, 8'h08};
    play(0);
    idle(TIMEOUT);
    sq = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    play(0);
    idle(2);
    check("t5_abort_errs", 32'(err_count), 32'd1);
    check("t5_abort_addr", 32'(reg_addr), 32'h0000_0004);

    // Reset in the middle of a frame.
    do_reset();
    sq = '{8'hAA, 8'h05, 8'h04, 8'h00};
    play(0);
    do_reset();
    sq = '{8'hAA, 8'h01, 8'h01, 8'h01};
    play(0);
    idle(2);
    check("t6_errs",   32'(err_count),  32'd0);
    check("t6_addr",   32'(reg_addr),   32'd0);
    check("t6_target", 32'(cmd_target), 32'h01);
    check("t6_action", 32'(cmd_action), 32'h01);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      sq = '{8'hAA, 8'h07};
      play(0);
    end
    idle(2);
    check("t6_sat", 32'(err_count), 32'hFF);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rand_frame();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(TIMEOUT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
